// File: rtl/my_struct_package.sv
// Shared types for the L2 responder: trace command, cache line,
// bus/snoop/MESI encodings and the responder FSM states.
package my_struct_package;

  localparam int TAG_W  = 12;
  localparam int SET_W  = 14;
  localparam int BYTE_W = 6;
  localparam int LRU_W  = 3;
  localparam int N_W    = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    BUS_NONE       = 3'd0,
    BUS_READ       = 3'd1,
    BUS_WRITE      = 3'd2,
    BUS_RWIM       = 3'd3,
    BUS_INVALIDATE = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    SNOOP_HIT   = 2'd0,
    SNOOP_HITM  = 2'd1,
    SNOOP_NOHIT = 2'd2
  } snoop_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ISSUE,
    ST_WAIT_MEM,
    ST_RESPOND
  } state_t;

  typedef struct packed {
    logic [N_W-1:0]    n;
    logic [TAG_W-1:0]  tag;
    logic [SET_W-1:0]  set;
    logic [BYTE_W-1:0] byte_sel;
  } command_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    mesi_t            MESI_bits;
    logic [LRU_W-1:0] LRU;
  } cache_line_t;

  function automatic logic [31:0] line_addr(
    input logic [TAG_W-1:0] tag,
    input logic [SET_W-1:0] set
  );
    return {tag, set, {BYTE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/latency_counter.sv
// Down-counter for memory latency: load, decrement, zero flag.
module latency_counter
  import my_struct_package::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/l2_responder.sv
// L2 responder: services L1 misses/upgrades with bus ops,
// memory wait and a registered fill/update response.
module l2_responder
  import my_struct_package::*;
#(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  command_t    req_cmd,
  input  logic        req_hit,
  input  cache_line_t victim_line,
  output logic        resp_valid,
  output cache_line_t resp_line,
  output logic        bus_op_valid,
  output bus_op_t     bus_op,
  output logic [31:0] bus_addr,
  input  snoop_t      snoop_result,
  output logic        busy
);

  state_t           state;
  logic [N_W-1:0]   n_q;
  logic [TAG_W-1:0] tag_q;
  logic [SET_W-1:0] set_q;
  snoop_t           snoop_q;
  logic             cnt_zero;
  logic             is_fill;
  logic             is_inv;
  logic             is_hit;
  logic             is_evict;
  logic             unused_byte;

  assign req_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign unused_byte = ^req_cmd.byte_sel;

  assign is_fill  = (req_cmd.n <= 4'd2) && !req_hit;
  assign is_inv   = (req_cmd.n == 4'd1) && req_hit &&
                    (victim_line.MESI_bits == MESI_S);
  assign is_hit   = (req_cmd.n <= 4'd2) && req_hit && !is_inv;
  assign is_evict = (req_cmd.n == 4'd3) || (req_cmd.n == 4'd4);

  latency_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_ISSUE),
    .load_val (CNT_W'(MEM_LATENCY - 1)),
    .dec      (state == ST_WAIT_MEM),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      n_q          <= '0;
      tag_q        <= '0;
      set_q        <= '0;
      snoop_q      <= SNOOP_HIT;
      resp_valid   <= 1'b0;
      resp_line    <= '0;
      bus_op_valid <= 1'b0;
      bus_op       <= BUS_NONE;
      bus_addr     <= '0;
    end else begin
      resp_valid   <= 1'b0;
      bus_op_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            n_q   <= req_cmd.n;
            tag_q <= req_cmd.tag;
            set_q <= req_cmd.set;
            unique case (1'b1)
              is_fill: begin
                bus_op_valid <= 1'b1;
                if (victim_line.MESI_bits == MESI_M) begin
                  state    <= ST_WRITEBACK;
                  bus_op   <= BUS_WRITE;
                  bus_addr <= line_addr(victim_line.tag,
                                        req_cmd.set);
                end else begin
                  state    <= ST_ISSUE;
                  bus_op   <= (req_cmd.n == 4'd1) ?
                              BUS_RWIM : BUS_READ;
                  bus_addr <= line_addr(req_cmd.tag,
                                        req_cmd.set);
                end
              end
              is_inv: begin
                state        <= ST_ISSUE;
                bus_op_valid <= 1'b1;
                bus_op       <= BUS_INVALIDATE;
                bus_addr     <= line_addr(req_cmd.tag,
                                          req_cmd.set);
              end
              is_hit: begin
                state      <= ST_RESPOND;
                resp_valid <= 1'b1;
                resp_line  <= '{
                  tag:       req_cmd.tag,
                  MESI_bits: (req_cmd.n == 4'd1) ?
                             MESI_M : victim_line.MESI_bits,
                  LRU:       '0
                };
              end
              is_evict: begin
                state      <= ST_RESPOND;
                resp_valid <= 1'b1;
                resp_line  <= '{
                  tag:       victim_line.tag,
                  MESI_bits: MESI_I,
                  LRU:       victim_line.LRU
                };
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_WRITEBACK: begin
          state        <= ST_ISSUE;
          bus_op_valid <= 1'b1;
          bus_op       <= (n_q == 4'd1) ? BUS_RWIM : BUS_READ;
          bus_addr     <= line_addr(tag_q, set_q);
        end
        ST_ISSUE: begin
          // An upgrade invalidate needs no memory data
          if (bus_op == BUS_INVALIDATE) begin
            state      <= ST_RESPOND;
            resp_valid <= 1'b1;
            resp_line  <= '{tag: tag_q, MESI_bits: MESI_M, LRU: '0};
          end else begin
            state   <= ST_WAIT_MEM;
            snoop_q <= snoop_result;
          end
        end
        ST_WAIT_MEM: begin
          if (cnt_zero) begin
            state      <= ST_RESPOND;
            resp_valid <= 1'b1;
            resp_line  <= '{
              tag:       tag_q,
              MESI_bits: (n_q == 4'd1) ? MESI_M :
                         (snoop_q == SNOOP_NOHIT) ? MESI_E : MESI_S,
              LRU:       '0
            };
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule
